seq_chunk_addsub: RTL and testbench

- Parametrised, multi-cycle successor to the team's 32-bit ripple-carry full-adder chain.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, using a registered carry between chunks, so the carry chain per cycle is only CHUNK bits long.
- Start/busy/done handshake; feeds ALU datapath experiments where WIDTH and area/latency trade-off vary.
- Reports sum, carry-out, signed overflow and zero flags.

---
 rtl/seq_chunk_addsub.sv | 91 +++++++++
 tb/tb_seq_chunk_addsub.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_addsub.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock with a registered inter-chunk carry.
// Latency: done is visible in the cycle after the WIDTH/CHUNK-th RUN edge that follows the accept edge.
// Backpressure: start is sampled only while busy=0; requests made during RUN are dropped, never queued.
module seq_chunk_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8   // WIDTH must be a multiple of CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             cin,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic             done
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, out_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [CHUNK:0]   slice_sum;
    logic             accept, last;
    int               base;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(N - 1));

    // One chunk of the sum per cycle; out_nxt is the result word with this slice merged in.
    always_comb begin
        base      = int'(cnt) * CHUNK;
        slice_sum = {1'b0, opa[base +: CHUNK]} + {1'b0, opb[base +: CHUNK]} + {{CHUNK{1'b0}}, carry};
        out_nxt   = out;
        out_nxt[base +: CHUNK] = slice_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1, so the inversion and forced carry happen once at load.
            opa   <= in1;
            opb   <= op ? ~in2 : in2;
            carry <= op ? 1'b1 : cin;
            cnt   <= '0;
            out   <= '0;
        end else if (state == RUN) begin
            out   <= out_nxt;
            carry <= slice_sum[CHUNK];
            cnt   <= cnt + CW'(1);
            if (last) begin
                cout <= slice_sum[CHUNK];
                ovf  <= (opa[WIDTH-1] == opb[WIDTH-1]) && (slice_sum[CHUNK-1] != opa[WIDTH-1]);
                zero <= (out_nxt == '0);
            end
        end
    end
endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Bench for seq_chunk_addsub: three configurations (32/8, 16/4, 16/16) checked every cycle against an
// arithmetic reference model, plus directed cases with literal expected values.
module tb_seq_chunk_addsub;
    localparam int WS [3] = '{32, 16, 16};
    localparam int CS [3] = '{8, 4, 16};

    logic        clk = 1'b0;
    logic        reset, op, cin;
    logic [2:0]  start;
    logic [31:0] in1, in2;
    logic [31:0] out0;
    logic [15:0] out1, out2;
    logic [2:0]  cout_w, ovf_w, zero_w, busy_w, done_w;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    seq_chunk_addsub #(.WIDTH(32), .CHUNK(8)) u_d0 (
        .clk(clk), .reset(reset), .start(start[0]), .op(op), .cin(cin),
        .in1(in1), .in2(in2), .out(out0), .cout(cout_w[0]), .ovf(ovf_w[0]),
        .zero(zero_w[0]), .busy(busy_w[0]), .done(done_w[0]));

    seq_chunk_addsub #(.WIDTH(16), .CHUNK(4)) u_d1 (
        .clk(clk), .reset(reset), .start(start[1]), .op(op), .cin(cin),
        .in1(in1[15:0]), .in2(in2[15:0]), .out(out1), .cout(cout_w[1]), .ovf(ovf_w[1]),
        .zero(zero_w[1]), .busy(busy_w[1]), .done(done_w[1]));

    seq_chunk_addsub #(.WIDTH(16), .CHUNK(16)) u_d2 (
        .clk(clk), .reset(reset), .start(start[2]), .op(op), .cin(cin),
        .in1(in1[15:0]), .in2(in2[15:0]), .out(out2), .cout(cout_w[2]), .ovf(ovf_w[2]),
        .zero(zero_w[2]), .busy(busy_w[2]), .done(done_w[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_out(input int i);
        case (i)
            0:       return out0;
            1:       return {16'h0, out1};
            default: return {16'h0, out2};
        endcase
    endfunction

    function automatic longint lowmask(input int k);
        longint one = 1;
        return (k <= 0) ? 0 : ((one << k) - 1);
    endfunction

    // Plain integer arithmetic: unsigned result/carry and signed range overflow.
    function automatic void compute(input int w, input logic o, input logic [31:0] a, input logic [31:0] b,
                                    input logic c, output logic [31:0] r, output logic co, output logic ov);
        longint one = 1;
        longint m, ua, ub, sa, sb, u, s;
        m  = lowmask(w);
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
        sb = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
        if (!o) begin
            u  = ua + ub + longint'(c);
            s  = sa + sb + longint'(c);
            co = (u >= (one << w));
        end else begin
            u  = ua - ub;
            s  = sa - sb;
            co = (ua >= ub);
        end
        r  = 32'(u & m);
        ov = (s > ((one << (w - 1)) - 1)) || (s < -(one << (w - 1)));
    endfunction

    // Model: ph = cycles since accept (0 = idle, 1..N = running, N+1 = done cycle).
    int          ph [3];
    int          ndone [3];
    logic [31:0] res [3], hold [3];
    logic        rcout [3], rovf [3], ecout [3], eovf [3], ezero [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            ph[i] = 0; ndone[i] = 0; res[i] = '0; hold[i] = '0;
            rcout[i] = 0; rovf[i] = 0; ecout[i] = 0; eovf[i] = 0; ezero[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int n;
            n = WS[i] / CS[i];
            if (reset) begin
                ph[i] = 0; hold[i] = '0; ecout[i] = 0; eovf[i] = 0; ezero[i] = 0;
            end else if (ph[i] == 0 || ph[i] == n + 1) begin
                if (start[i]) begin
                    compute(WS[i], op, in1, in2, cin, res[i], rcout[i], rovf[i]);
                    ph[i] = 1;
                end else begin
                    ph[i] = 0;
                end
            end else begin
                ph[i]++;
                if (ph[i] == n + 1) begin
                    hold[i] = res[i]; ecout[i] = rcout[i]; eovf[i] = rovf[i];
                    ezero[i] = (res[i] == 0);
                    ndone[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                int n;
                logic [31:0] eo;
                n = WS[i] / CS[i];
                if (ph[i] == 0)      eo = hold[i];
                else if (ph[i] <= n) eo = 32'(longint'(res[i]) & lowmask((ph[i] - 1) * CS[i]));
                else                 eo = res[i];
                chk($sformatf("out%0d", i),  dut_out(i), eo);
                chk($sformatf("busy%0d", i), busy_w[i], (ph[i] >= 1 && ph[i] <= n));
                chk($sformatf("done%0d", i), done_w[i], (ph[i] == n + 1));
                chk($sformatf("cout%0d", i), cout_w[i], ecout[i]);
                chk($sformatf("ovf%0d", i),  ovf_w[i],  eovf[i]);
                chk($sformatf("zero%0d", i), zero_w[i], ezero[i]);
            end
        end
    end

    // Returns at the negedge of the done cycle; lat = edges from accept to done, bc = busy cycles seen.
    task automatic do_op(input int i, input logic o, input logic [31:0] a, input logic [31:0] b,
                         input logic c, output int lat, output int bc);
        @(negedge clk);
        op = o; in1 = a; in2 = b; cin = c; start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        lat = 0; bc = 0;
        while (done_w[i] !== 1'b1 && lat < 64) begin
            if (busy_w[i] === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 64) chk("done_timeout", 32'(lat), 32'd0);
    endtask

    initial begin
        int lat, bc, gap, cyc, seen;
        reset = 1'b1; start = '0; op = 1'b0; cin = 1'b0; in1 = '0; in2 = '0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_out", out0, 32'h0);
        chk("rst_busy", busy_w, 3'b000);
        chk("rst_done", done_w, 3'b000);
        reset = 1'b0;

        do_op(0, 1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, bc);
        chk("addc_out", out0, 32'h0);
        chk("addc_cout", cout_w[0], 1'b1);
        chk("addc_zero", zero_w[0], 1'b1);
        chk("addc_ovf", ovf_w[0], 1'b0);
        chk("addc_lat", 32'(lat), 32'd4);
        chk("addc_busycyc", 32'(bc), 32'd4);
        chk("model_res0", res[0], 32'h0);
        @(negedge clk);
        chk("done_one_cycle", done_w[0], 1'b0);

        do_op(0, 1'b0, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, bc);
        chk("addv_out", out0, 32'h8000_0000);
        chk("addv_cout", cout_w[0], 1'b0);
        chk("addv_ovf", ovf_w[0], 1'b1);
        chk("model_ovf0", rovf[0], 1'b1);

        do_op(0, 1'b0, 32'h10, 32'h20, 1'b1, lat, bc);
        chk("addcin_out", out0, 32'h31);

        do_op(0, 1'b1, 32'd5, 32'd7, 1'b1, lat, bc);
        chk("sub57_out", out0, 32'hFFFF_FFFE);
        chk("sub57_cout", cout_w[0], 1'b0);
        chk("sub57_ovf", ovf_w[0], 1'b0);

        do_op(0, 1'b1, 32'h8000_0000, 32'd1, 1'b0, lat, bc);
        chk("subv_out", out0, 32'h7FFF_FFFF);
        chk("subv_cout", cout_w[0], 1'b1);
        chk("subv_ovf", ovf_w[0], 1'b1);

        do_op(0, 1'b1, 32'd9, 32'd9, 1'b0, lat, bc);
        chk("sub99_out", out0, 32'h0);
        chk("sub99_zero", zero_w[0], 1'b1);
        chk("sub99_cout", cout_w[0], 1'b1);

        // start pulsed mid-RUN with different operands must not disturb the result
        @(negedge clk);
        op = 1'b0; in1 = 32'h1234_0000; in2 = 32'h0000_5678; cin = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b1; in1 = 32'hDEAD_BEEF; in2 = 32'h1111_1111; op = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        lat = 0;
        while (done_w[0] !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
        chk("ignore_out", out0, 32'h1234_5678);

        // back-to-back: start held in the done cycle
        do_op(0, 1'b0, 32'd1, 32'd2, 1'b0, lat, bc);
        in1 = 32'd100; in2 = 32'd23; op = 1'b0; cin = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        gap = 1;
        while (done_w[0] !== 1'b1 && gap < 64) begin @(negedge clk); gap++; end
        chk("b2b_gap", 32'(gap), 32'd5);
        chk("b2b_out", out0, 32'd123);

        // reset sampled on the 2nd RUN edge
        @(negedge clk);
        op = 1'b0; in1 = 32'hAAAA_AAAA; in2 = 32'h5555_5555; cin = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstrun_out", out0, 32'h0);
        chk("rstrun_busy", busy_w[0], 1'b0);
        chk("rstrun_flags", {cout_w[0], ovf_w[0], zero_w[0], done_w[0]}, 4'b0000);
        seen = 0;
        repeat (6) begin @(negedge clk); if (done_w[0] === 1'b1) seen++; end
        chk("rstrun_nodone", 32'(seen), 32'd0);
        do_op(0, 1'b0, 32'd3, 32'd4, 1'b0, lat, bc);
        chk("after_rst_out", out0, 32'd7);

        do_op(1, 1'b0, 32'hFFFF, 32'h1, 1'b0, lat, bc);
        chk("w16c4_lat", 32'(lat), 32'd4);
        chk("w16c4_cout", cout_w[1], 1'b1);
        do_op(2, 1'b1, 32'h8000, 32'h1, 1'b0, lat, bc);
        chk("w16c16_lat", 32'(lat), 32'd1);
        chk("w16c16_out", {16'h0, out2}, 32'h7FFF);
        chk("w16c16_ovf", ovf_w[2], 1'b1);

        // random sweep on all three instances; the model compares every cycle
        ndone[1] = 0; ndone[2] = 0;
        cyc = 0;
        while ((ndone[1] < 1000 || ndone[2] < 1000) && cyc < 30000) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) start[i] = ($urandom_range(0, 3) != 0);
            op  = $urandom_range(0, 1);
            cin = $urandom_range(0, 1);
            case ($urandom_range(0, 3))
                0:       begin in1 = 32'hFFFF_FFFF; in2 = $urandom; end
                1:       begin in1 = 32'h8000_8000 ^ {$urandom_range(0, 1), 15'h0, $urandom_range(0, 1), 15'h0};
                               in2 = {$urandom_range(0, 1), 15'h0, $urandom_range(0, 1), 15'h1}; end
                default: begin in1 = $urandom; in2 = $urandom; end
            endcase
            cyc++;
        end
        start = '0;
        repeat (8) @(negedge clk);
        chk("sweep_ops1", 32'(ndone[1] >= 1000), 32'd1);
        chk("sweep_ops2", 32'(ndone[2] >= 1000), 32'd1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
